// File: rtl/regfile_write_port.sv
// Write side of the 32x64 register file: write-back stage, one-hot commit decoder,
// flop array and sequenced bulk clear. Optional macro REGFILE_WB_BYPASS_EN forwards the pending write onto regs.
module regfile_write_port #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        wr_en,
    input  logic [DEPTH_LOG2-1:0]                       wr_addr,
    input  logic [WIDTH-1:0]                            wr_data,
    output logic                                        wr_ready,
    input  logic                                        clr_req,
    output logic                                        clr_busy,
    output logic [(2**DEPTH_LOG2)-1:0][WIDTH-1:0]       regs
);

    localparam int NREGS = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] ZERO_IDX = DEPTH_LOG2'(ZERO_REG);
    localparam logic [DEPTH_LOG2-1:0] LAST_CLR = DEPTH_LOG2'(NREGS - 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]                  r_state;
    logic                        r_wb_valid;
    logic [DEPTH_LOG2-1:0]       r_wb_addr;
    logic [WIDTH-1:0]            r_wb_data;
    logic [DEPTH_LOG2-1:0]       r_cnt;
    logic [NREGS-1:0][WIDTH-1:0] r_regs;

    logic [NREGS-1:0]            w_wr_dec;
    logic [NREGS-1:0]            w_clr_dec;
    logic                        w_accept;

    assign wr_ready = (r_state == S_IDLE);
    assign clr_busy = (r_state != S_IDLE);
    assign w_accept = wr_en && wr_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_cnt      <= '0;
        end else begin
            r_wb_valid <= w_accept;
            if (w_accept) begin
                r_wb_addr <= wr_addr;
                r_wb_data <= wr_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (clr_req) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_cnt   <= '0;
                    r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CLR) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Commit and clear never coincide: no write is accepted while the clear runs.
    always_comb begin
        w_wr_dec  = '0;
        w_clr_dec = '0;
        if (r_wb_valid && (r_wb_addr != ZERO_IDX)) w_wr_dec[r_wb_addr] = 1'b1;
        if (r_state == S_CLEAR) w_clr_dec[r_cnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_regs <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (w_clr_dec[i])     r_regs[i] <= '0;
                else if (w_wr_dec[i]) r_regs[i] <= r_wb_data;
            end
        end
    end

    always_comb begin
        regs = r_regs;
`ifdef REGFILE_WB_BYPASS_EN
        if (r_wb_valid && (r_wb_addr != ZERO_IDX)) regs[r_wb_addr] = r_wb_data;
`else
`endif
        regs[ZERO_REG] = '0;
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench for regfile_write_port: stimulus pushes expected post-edge state
// from an architectural model; a negedge monitor pops and compares.
module tb_regfile_write_port;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  wr_en;
    logic [4:0]            wr_addr;
    logic [63:0]           wr_data;
    logic                  wr_ready;
    logic                  clr_req;
    logic                  clr_busy;
    logic [31:0][63:0]     regs;

    always #5 clk = ~clk;

    regfile_write_port #(.WIDTH(64), .DEPTH_LOG2(5), .ZERO_REG(31)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .regs     (regs)
    );

    typedef struct {
        logic [31:0][63:0] regs;
        logic              rdy;
        logic              busy;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Architectural model: register contents, one pending write, busy cycles remaining.
    logic [63:0] m_regs [32];
    bit          m_pend = 0;
    int          m_pa   = 0;
    logic [63:0] m_pd   = '0;
    int          m_busy = 0;

    task automatic step(input bit en, input int addr, input logic [63:0] data,
                        input bit clr, input bit rst_n);
        exp_t e;
        bit   ready;
        wr_en   = en;
        wr_addr = addr[4:0];
        wr_data = data;
        clr_req = clr;
        reset   = rst_n;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_pend = 0;
            m_busy = 0;
        end else begin
            ready = (m_busy == 0);
            if (m_pend && m_pa != 31) m_regs[m_pa] = m_pd;
            // busy==32 is the drain cycle; busy 31..1 clear registers 0..30
            if (m_busy >= 1 && m_busy <= 31) m_regs[31 - m_busy] = '0;
            m_pend = en && ready;
            if (m_pend) begin
                m_pa = addr;
                m_pd = data;
            end
            if (m_busy > 0) m_busy--;
            else if (clr) m_busy = 32;
        end
        for (int i = 0; i < 32; i++) e.regs[i] = (i == 31) ? 64'd0 : m_regs[i];
`ifdef REGFILE_WB_BYPASS_EN
        if (m_pend && m_pa != 31) e.regs[m_pa] = m_pd;
`endif
        e.rdy  = (m_busy == 0);
        e.busy = (m_busy != 0);
        q.push_back(e);
    endtask

    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                me = q.pop_front();
                vectors++;
                if (regs !== me.regs) begin
                    miscompares++;
                    for (int i = 0; i < 32; i++) begin
                        if (regs[i] !== me.regs[i]) begin
                            $display("FAIL regs[%0d] vec %0d: got %h exp %h", i, vectors, regs[i], me.regs[i]);
                            break;
                        end
                    end
                end
                if (wr_ready !== me.rdy) begin
                    miscompares++;
                    $display("FAIL wr_ready vec %0d: got %b exp %b", vectors, wr_ready, me.rdy);
                end
                if (clr_busy !== me.busy) begin
                    miscompares++;
                    $display("FAIL clr_busy vec %0d: got %b exp %b", vectors, clr_busy, me.busy);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;

        // reset, then single write
        step(0, 0, 64'd0, 0, 0);
        step(0, 0, 64'd0, 0, 0);
        step(1, 5, 64'd550, 0, 1);
        step(0, 0, 64'd0, 0, 1);
        step(0, 0, 64'd0, 0, 1);

        // back-to-back, same address twice
        step(1, 3, 64'hA, 0, 1);
        step(1, 3, 64'hB, 0, 1);
        step(1, 7, 64'hC, 0, 1);
        step(0, 0, 64'd0, 0, 1);
        step(0, 0, 64'd0, 0, 1);

        // zero register
        step(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        step(0, 0, 64'd0, 0, 1);
        step(0, 0, 64'd0, 0, 1);

        // bypass-visible write
        step(1, 9, 64'h1234, 0, 1);
        step(0, 0, 64'd0, 0, 1);
        step(0, 0, 64'd0, 0, 1);

        // fill, then clear with concurrent write; writes and clr_req during busy
        for (int i = 0; i < 31; i++) step(1, i, 64'(i + 1), 0, 1);
        step(1, 20, 64'h55, 1, 1);
        for (int k = 1; k <= 32; k++) step(1, k % 31, 64'hDEAD_0000 + 64'(k), (k == 5), 1);
        step(1, 4, 64'h77, 0, 1);
        step(0, 0, 64'd0, 0, 1);
        step(0, 0, 64'd0, 0, 1);

        // reset at clear counter 10
        for (int i = 0; i < 31; i++) step(1, i, 64'(i + 100), 0, 1);
        step(0, 0, 64'd0, 1, 1);
        for (int k = 0; k < 11; k++) step(0, 0, 64'd0, 0, 1);
        step(0, 0, 64'd0, 0, 0);
        step(1, 2, 64'h99, 0, 1);
        step(0, 0, 64'd0, 0, 1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 99) < 70,
                 int'($urandom_range(0, 31)),
                 {$urandom, $urandom},
                 $urandom_range(0, 99) < 4,
                 !($urandom_range(0, 199) == 0));
        end
        step(0, 0, 64'd0, 0, 1);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 32x64 register file; the read side is the 32:1 x 64-bit read multiplexors.
- Accepts one write-back request per cycle and registers it in a write-back stage.
- Commits the request through a 5:32 one-hot write decoder into a 32-entry 64-bit register array.
- Presents the whole array as a packed [31:0][63:0] bus that feeds the read multiplexors directly. Also provides a sequenced bulk-clear operation.

Parameters:
- WIDTH, 64, data width of each register.
- DEPTH_LOG2, 5, address width; register count = 2**DEPTH_LOG2 = 32.
- ZERO_REG, 31, index of the hardwired-zero register (XZR).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled at posedge clk; asserted when 0.
- wr_en  input  1  write request valid.
- wr_addr  input  5  destination register index.
- wr_data  input  64  write data.
- wr_ready  output  1  write accepted this cycle when wr_en && wr_ready.
- clr_req  input  1  request zeroing of all registers; single-cycle pulse or level.
- clr_busy  output  1  high while a clear sequence is in progress.
- regs  output  32x64  packed register array, regs[i] = register i.

Behaviour:
- Reset (reset==0 at posedge):
  - all 32 registers <= 0; wb_valid <= 0; state <= IDLE; clear counter <= 0.
  - After reset: wr_ready=1, clr_busy=0, regs all zero.
- Write pipeline:
  - Edge N, capture (wr_en && wr_ready): wb_valid<=1, wb_addr<=wr_addr, wb_data<=wr_data.
  - Edge N+1, commit (wb_valid): decoder asserts the one-hot enable bit wb_addr, and regs[wb_addr] <= wb_data.
  - Capture without accept: wb_valid<=0.
  - Back-to-back writes sustain one per cycle, including repeated writes to the same address; the later write wins.
- Zero register:
  - A write with addr == ZERO_REG is accepted and consumes a slot but never changes regs[31].
  - regs[31] reads 0 at all times.
- FSM states: IDLE, DRAIN, CLEAR.
  - IDLE: wr_ready=1, clr_busy=0. If clr_req, go to DRAIN. A write presented in the same cycle as clr_req is still accepted.
  - DRAIN, 1 cycle: wr_ready=0, clr_busy=1. Commits any pending wb entry. Counter <= 0. Go to CLEAR.
  - CLEAR: wr_ready=0, clr_busy=1. Each cycle regs[counter] <= 0 and counter++. After counter==30 is written, go to IDLE.
- Clear sequence timing:
  - From the clr_req edge, busy lasts 32 cycles: DRAIN 1 + CLEAR 31.
  - First write accepted again in the cycle after the last clear.
- clr_req while not in IDLE is ignored; it is not queued.
- Reset asserted mid-write or mid-clear overrides everything: array zeroed, state IDLE, pending wb entry dropped.
- wr_ready depends only on state, never combinationally on wr_en or clr_req.
- Array and decoder are pure flops and enable logic; no latches, and no X on regs after reset.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - While wb_valid && wb_addr != ZERO_REG, regs[wb_addr] shows wb_data combinationally.
  - A write becomes visible on regs one cycle after capture, i.e. in the same cycle as the commit edge's input.
  - Effective read-after-write latency is 1 cycle.
  - Architectural state is identical to the non-bypass build.
- Undefined:
  - regs shows the raw flop array only.
  - Write becomes visible after the commit edge, a 2-cycle read-after-write latency.

Test Plan:
- Reset then write: hold reset=0 for 2 cycles, release; write addr 5 data 64'd550. Required:
  - regs all 0 after reset.
  - regs[5]==550 after the second posedge following capture; all other regs 0.
- Back-to-back writes: addr 3=0xA, addr 3=0xB, addr 7=0xC on consecutive cycles. Required:
  - wr_ready stays 1 throughout.
  - Final regs[3]==0xB and regs[7]==0xC.
- Zero register: write addr 31 data 0xFFFF_FFFF_FFFF_FFFF. Required:
  - Write is accepted with wr_ready=1.
  - regs[31] remains 0 on every cycle.
- Clear with concurrent write: fill regs 0..30 with value i+1, then pulse clr_req together with a write of addr 20=0x55. Required:
  - The write is accepted.
  - clr_busy=1 and wr_ready=0 for exactly 32 cycles.
  - Afterwards all regs==0.
  - A write during busy is not accepted, and a second clr_req during busy has no effect.
- Reset mid-clear: start a clear, then assert reset=0 at CLEAR counter==10. Required:
  - Next cycle state is IDLE with clr_busy=0 and wr_ready=1.
  - All regs==0.
- Build with REGFILE_WB_BYPASS_EN: write addr 9=0x1234. Required:
  - regs[9]==0x1234 in the cycle immediately after the capture edge.
  - Without the macro, regs[9] still reads 0 in that cycle.
